// File: rtl/serial_sub_nb.sv
`timescale 1ns / 1ps
// serial_sub_nb: bit-serial two's-complement subtractor, z = x - y - bin.
// One full-subtractor cell is reused for each bit, LSB first, so an operation
// takes WIDTH clocks. A start/busy/done handshake lets a controller issue
// operations back to back and collect the difference and borrow-out.
module serial_sub_nb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             bout
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // Operand shift registers, partial result and the running borrow.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Registered results; they hold until the next operation completes.
  logic [WIDTH-1:0] z_q, z_d;
  logic             bout_q, bout_d;

  logic accept;
  logic last_bit;
  logic bit_a;
  logic bit_b;
  logic diff_bit;
  logic borrow_next;

  // A new request is only taken when no bits are in flight.
  assign accept   = start && (state_q != S_RUN);
  assign last_bit = (cnt_q == LAST_BIT);

  // Full-subtractor cell operating on the current LSBs.
  assign bit_a       = a_q[0];
  assign bit_b       = b_q[0];
  assign diff_bit    = bit_a ^ bit_b ^ br_q;
  assign borrow_next = (~bit_a & bit_b) | (~bit_a & br_q) | (bit_b & br_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH edges, DONE exactly one cycle.
  always_comb begin
    // NOTE: default first, so no branch leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  assign z    = z_q;
  assign bout = bout_q;

  // Datapath next values: load on accept, shift one bit per RUN edge,
  // publish the result on the edge that handles the MSB.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    r_d    = r_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    z_d    = z_q;
    bout_d = bout_q;
    if (accept) begin
      a_d   = x;
      b_d   = y;
      br_d  = bin;
      cnt_d = '0;
    end else if (state_q == S_RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = borrow_next;
      r_d   = {diff_bit, r_q[WIDTH-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
      if (last_bit) begin
        z_d    = {diff_bit, r_q[WIDTH-1:1]};
        bout_d = borrow_next;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the wide registers are reset too, so z and bout read 0 rather than X after reset.
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      z_q    <= '0;
      bout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
      bout_q <= bout_d;
    end
  end

endmodule
